rca16_seq: RTL and testbench
============================

RCA16_SEQ -- requirements
Module: rca16_seq

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request an addition; sampled only in IDLE.
REQ-005 A  input  W  operand A, captured when start is accepted.
REQ-006 B  input  W  operand B, captured when start is accepted.
REQ-007 Cin  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high while in ISSUE or CAPTURE.
REQ-009 done  output  1  registered one-cycle completion pulse.
REQ-010 S  output  W  registered sum, updated only at completion.
REQ-011 Cout  output  1  registered carry-out of the MSB slice, updated only at completion.
REQ-012 ovf  output  1  registered two's-complement overflow, updated only at completion.

Function
REQ-013 The block shall contain exactly one RCA_4bits instance (clk, enable, A[3:0], B[3:0], Cin, Q[4:0]); Q = A+B+Cin registered on the edge where enable=1, held otherwise; it shall be the only adder in the block.
REQ-014 FSM states: IDLE, ISSUE, CAPTURE, DONE; encoding is free.
REQ-015 IDLE: start=1 at an edge -> latch A, B, Cin; clear nibble index to 0; carry register <= Cin; go to ISSUE.
REQ-016 ISSUE: RCA enable=1, RCA A/B = nibble[index] of the latched operands, RCA Cin = carry register; next edge -> CAPTURE.
REQ-017 CAPTURE: RCA enable=0; at the edge, partial-sum nibble[index] <= Q[3:0], carry register <= Q[4]; index < NIBBLES-1 -> index+1 and ISSUE; otherwise -> DONE.
REQ-018 Transition from the final CAPTURE: S <= full partial sum including the final nibble, Cout <= Q[4], ovf <= (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), done <= 1.
REQ-019 DONE: lasts exactly one cycle; next edge -> IDLE with done <= 0.
REQ-020 Latency: done is high in the cycle following the 2*NIBBLES-th rising edge after the edge that accepted start (8 edges for NIBBLES=4); throughput one addition per 2*NIBBLES+2 cycles.
REQ-021 RCA enable, A, B, and Cin inputs shall be 0 in IDLE, CAPTURE, and DONE.
REQ-022 start in ISSUE, CAPTURE, or DONE shall be ignored, with no queuing; operand input changes after acceptance shall not affect the result.
REQ-023 S, Cout, and ovf shall hold their last values from completion until the next completion; they shall not change during an operation.
REQ-024 Carry shall propagate across all slices, e.g. 0x0FFF+0x0001 -> 0x1000; 0xFFFF+0x0000 with Cin=1 -> S=0x0000, Cout=1.

Reset
REQ-025 rst_n=0 at any edge, including mid-operation: state <= IDLE, index <= 0, carry <= 0, busy=0, done=0, S=0, Cout=0, ovf=0, RCA enable=0.
REQ-026 A start=1 sampled at the same edge as rst_n=0 shall be discarded; the first start is accepted at the first edge with rst_n=1.
REQ-027 The RCA_4bits Q value left over from before reset shall not be observable on S after reset.

Verification
REQ-028 A=0x0001, B=0x0007, Cin=0 -> done 8 edges after acceptance; S=0x0008, Cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-029 A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, ovf=0; A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, ovf=1.
REQ-030 A=0x8000, B=0x8000, Cin=1 -> S=0x0001, Cout=1, ovf=1; A=0x9A0F, B=0x0AF1, Cin=1 -> S=0xA501, Cout=0, ovf=0.
REQ-031 start re-pulsed with different operands during busy and during DONE -> ignored; result matches the first operands; one done pulse only.
REQ-032 rst_n=0 for one cycle during the third CAPTURE -> no done pulse; outputs all 0; a new start afterwards completes correctly.
REQ-033 Back-to-back: start held high continuously -> a new operation is accepted on the IDLE edge after each DONE; every result is correct; done pulses are separated by 9 low cycles.

Source files
------------

// File: rtl/rca16_seq.sv
// Sequential W-bit adder: one registered 4-bit RCA slice reused nibble by nibble, LSB first.
// Latency 2*NIBBLES edges from accepted start to done; start outside IDLE is dropped (no queuing).

module RCA_4bits (
    input  logic       clk,
    input  logic       enable,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [4:0] Q
);
    logic [4:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign Q = q_q;
endmodule

module rca16_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    psum_q, psum_d;
    logic [W-1:0]    s_q, s_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            rca_en;
    logic [3:0]      rca_a, rca_b;
    logic            rca_cin;
    logic [4:0]      rca_q;
    logic [3:0]      nib_a, nib_b;

    RCA_4bits u_rca (
        .clk    (clk),
        .enable (rca_en),
        .A      (rca_a),
        .B      (rca_b),
        .Cin    (rca_cin),
        .Q      (rca_q)
    );

    always_comb begin
        nib_a = 4'b0000;
        nib_b = 4'b0000;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[i*4 +: 4];
                nib_b = b_q[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        rca_en  = 1'b0;
        rca_a   = 4'b0000;
        rca_b   = 4'b0000;
        rca_cin = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    psum_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rca_en  = 1'b1;
                rca_a   = nib_a;
                rca_b   = nib_b;
                rca_cin = carry_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        psum_d[i*4 +: 4] = rca_q[3:0];
                    end
                end
                carry_d = rca_q[4];
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    // Final slice: publish the sum assembled this very edge.
                    s_d     = psum_d;
                    cout_d  = rca_q[4];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (psum_d[W-1] != a_q[W-1]);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE);
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_rca16_seq.sv
// Bench for rca16_seq: per-cycle comparison against an edge-counting arithmetic model,
// plus literal results for directed operand pairs.
module tb_rca16_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         busy, done, Cout, ovf;
    logic [W-1:0] S;

    int vectors = 0;
    int miscompares = 0;

    rca16_seq #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: an accepted operation completes 2*N edges after acceptance.
    bit           chk_en = 1'b0;
    bit           m_active = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_cin = 1'b0;
    logic [W:0]   m_sum;
    logic [W-1:0] exp_s = '0;
    logic         exp_cout = 1'b0, exp_ovf = 1'b0, exp_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_cnt    = 0;
            exp_s    = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
            exp_done = 1'b0;
            chk_en   = 1'b1;
        end else if (!m_active) begin
            exp_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_a      = A;
                m_b      = B;
                m_cin    = Cin;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 2 * N) begin
                m_sum    = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                exp_s    = m_sum[W-1:0];
                exp_cout = m_sum[W];
                exp_ovf  = (m_a[W-1] == m_b[W-1]) && (exp_s[W-1] != m_a[W-1]);
                exp_done = 1'b1;
            end else if (m_cnt == 2 * N + 1) begin
                exp_done = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_busy;
        if (chk_en) begin
            exp_busy = m_active && (m_cnt < 2 * N);
            vectors++;
            if (busy !== exp_busy || done !== exp_done || S !== exp_s ||
                Cout !== exp_cout || ovf !== exp_ovf) begin
                miscompares++;
                $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b S=%h/%h Cout=%b/%b ovf=%b/%b (got/want)",
                         $time, busy, exp_busy, done, exp_done, S, exp_s, Cout, exp_cout, ovf, exp_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [W-1:0] es, input logic ec, input logic eo);
        vectors++;
        if (S !== es || Cout !== ec || ovf !== eo) begin
            miscompares++;
            $display("FAIL %s dut S=%h Cout=%b ovf=%b want S=%h Cout=%b ovf=%b", name, S, Cout, ovf, es, ec, eo);
        end
        vectors++;
        if (exp_s !== es || exp_cout !== ec || exp_ovf !== eo) begin
            miscompares++;
            $display("FAIL %s_model model S=%h Cout=%b ovf=%b want S=%h Cout=%b ovf=%b",
                     name, exp_s, exp_cout, exp_ovf, es, ec, eo);
        end
    endtask

    // Returns at the negedge of the done cycle; busy_cnt counts busy cycles seen before it.
    task automatic wait_done(input string name, output bit ok, output int busy_cnt);
        ok = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout done not seen within 40 cycles, want done=1", name);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        bit ok;
        int bc;
        A = a; B = b; Cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        wait_done(name, ok, bc);
        if (ok) begin
            check_lit(name, es, ec, eo);
            vectors++;
            if (bc != 2 * N) begin
                miscompares++;
                $display("FAIL %s_busy busy cycles=%0d want %0d", name, bc, 2 * N);
            end
        end
        tick();
    endtask

    initial begin
        bit ok;
        int bc;
        int dcount;

        // Start asserted during reset must be discarded; first edge out of reset accepts it.
        rst_n = 1'b0; start = 1'b1; A = 16'h0FFF; B = 16'h0001; Cin = 1'b0;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b done=%b S=%h Cout=%b ovf=%b want all 0", busy, done, S, Cout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        A = 16'h1234; B = 16'h4321;
        wait_done("carry_ripple", ok, bc);
        if (ok) check_lit("carry_ripple", 16'h1000, 1'b0, 1'b0);
        tick();

        run_op("small",      16'h0001, 16'h0007, 1'b0, 16'h0008, 1'b0, 1'b0);
        run_op("wrap",       16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("neg_ovf",    16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        run_op("mixed",      16'h9A0F, 16'h0AF1, 1'b1, 16'hA501, 1'b0, 1'b0);
        run_op("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Start re-pulsed while busy and during DONE must be ignored.
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 16'h7777; B = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_busy", ok, bc);
        if (ok) check_lit("ignore_busy", 16'h3333, 1'b0, 1'b0);
        A = 16'hABCD; B = 16'h0101; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        vectors++;
        if (dcount != 0) begin
            miscompares++;
            $display("FAIL ignore_done extra done pulses=%0d want 0", dcount);
        end
        tick();

        // Reset pulse during the third CAPTURE cycle aborts the operation.
        A = 16'h4444; B = 16'h1111; Cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        vectors++;
        if (dcount != 0 || S !== '0 || Cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset done pulses=%0d S=%h Cout=%b ovf=%b busy=%b want 0s", dcount, S, Cout, ovf, busy);
        end
        tick();
        run_op("after_reset", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Start held high with operands changing every cycle.
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (12) tick();

        // Random traffic with occasional resets and corner operands.
        for (int k = 0; k < 1500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       A = 16'hFFFF;
                1:       A = 16'h8000;
                2:       A = 16'h7FFF;
                default: A = W'($urandom);
            endcase
            B     = ($urandom_range(0, 4) == 0) ? 16'h0001 : W'($urandom);
            Cin   = 1'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
